// File: rtl/xpb_pkg.sv
// Shared definitions for the XPB reduction table generator.
//   XPB_DATA_W : default width of modulus, base and table entries
//   XPB_IDX_W  : default table index width
//   XPB_DEPTH  : default table depth (2**XPB_IDX_W)
//   xpb_state_e: generator FSM states
package xpb_pkg;

  localparam int unsigned XPB_DATA_W = 1024;
  localparam int unsigned XPB_IDX_W  = 5;
  localparam int unsigned XPB_DEPTH  = 2 ** XPB_IDX_W;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    ADD,
    REDUCE,
    DONE
  } xpb_state_e;

endpackage

// File: rtl/xpb_table_gen_mod_add.sv
// Modular adder used to step the table accumulator: res_c = (a + b) mod n.
// Stage 1 registers the DATA_W+1 bit sum when en is high; stage 2 is the
// conditional subtract of n, registered by the caller.
// Requires a < n and b < n so a single subtract suffices.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : capture a + b into the sum register
//   a, b, n    : addends and modulus
//   res_c      : reduced sum, combinational from the sum register
module xpb_table_gen_mod_add #(
  parameter int unsigned DATA_W = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] n,
  output logic [DATA_W-1:0] res_c
);

  logic [DATA_W:0] sum_q;
  logic            ge_n_c;

  // Stage 1: full-width sum, carry kept so the compare below is exact
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (en) begin
      sum_q <= {1'b0, a} + {1'b0, b};
    end
  end

  // Stage 2: subtract n when the sum reached or passed it
  assign ge_n_c = (sum_q >= {1'b0, n});
  assign res_c  = ge_n_c ? DATA_W'(sum_q - {1'b0, n}) : sum_q[DATA_W-1:0];

endmodule

// File: rtl/xpb_table_gen.sv
// Runtime writer for the XPB reduction lookup table: T[j] = j*B mod N,
// j = 0..2**IDX_W-1, emitted in address order over a valid/ready port.
// Optional build macro XPB_GEN_RANGE_CHECK_EN: rejects base >= modulus at
// start (done with err=1, no writes). Without it err is tied low.
//   clk, rst_n       : clock, synchronous active-low reset
//   start            : start request, accepted only when idle
//   modulus, base    : N and B, captured on an accepted start
//   busy             : accepted start through done cycle inclusive
//   done             : one-cycle pulse after the last entry is accepted
//   err              : range-check result, valid with done
//   wr_valid/wr_ready: table write handshake
//   wr_addr, wr_data : entry index and value
module xpb_table_gen
  import xpb_pkg::*;
#(
  parameter int unsigned DATA_W = XPB_DATA_W,
  parameter int unsigned IDX_W  = XPB_IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] modulus,
  input  logic [DATA_W-1:0] base,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [IDX_W-1:0]  wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  xpb_state_e        state_q, state_d;
  logic [DATA_W-1:0] mod_q, base_q;
  logic [DATA_W-1:0] res_c;
  logic              cap_en, add_en, acc_ld;
  logic              range_bad_c;

`ifdef XPB_GEN_RANGE_CHECK_EN
  // Compare on the live inputs so a bad pair never enters WRITE
  assign range_bad_c = (base >= modulus);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (cap_en) begin
      err <= range_bad_c;
    end
  end
`else
  assign range_bad_c = 1'b0;
  assign err         = 1'b0;
`endif

  // Next-state and datapath enables
  always_comb begin
    state_d = state_q;
    cap_en  = 1'b0;
    add_en  = 1'b0;
    acc_ld  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cap_en  = 1'b1;
          state_d = range_bad_c ? DONE : WRITE;
        end
      end
      WRITE: begin
        if (wr_ready) begin
          state_d = (wr_addr == LAST_IDX) ? DONE : ADD;
        end
      end
      ADD: begin
        add_en  = 1'b1;
        state_d = REDUCE;
      end
      REDUCE: begin
        acc_ld  = 1'b1;
        state_d = WRITE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, status and write port registers; wr_data doubles as the accumulator
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      mod_q    <= '0;
      base_q   <= '0;
    end else begin
      state_q  <= state_d;
      busy     <= (state_d != IDLE);
      done     <= (state_d == DONE);
      wr_valid <= (state_d == WRITE);
      if (cap_en) begin
        mod_q   <= modulus;
        base_q  <= base;
        wr_addr <= '0;
        wr_data <= '0;
      end
      if (acc_ld) begin
        wr_data <= res_c;
        wr_addr <= wr_addr + IDX_W'(1);
      end
    end
  end

  xpb_table_gen_mod_add #(
    .DATA_W(DATA_W)
  ) u_mod_add (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (add_en),
    .a    (wr_data),
    .b    (base_q),
    .n    (mod_q),
    .res_c(res_c)
  );

endmodule

// File: tb/tb_xpb_table_gen.sv
module tb_xpb_table_gen;
  import xpb_pkg::*;

  localparam int unsigned DW     = XPB_DATA_W;
  localparam int unsigned IW     = XPB_IDX_W;
  localparam int          DEPTH  = XPB_DEPTH;
  localparam int          BUDGET = 12 * DEPTH + 50;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] modulus;
  logic [DW-1:0] base;
  logic          busy;
  logic          done;
  logic          err;
  logic          wr_valid;
  logic          wr_ready;
  logic [IW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  int n_checks = 0;
  int n_fail   = 0;

  xpb_table_gen dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .modulus (modulus),
    .base    (base),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  always #5 clk = ~clk;

  // Reference entry straight from the definition: j*B mod N
  function automatic logic [DW-1:0] ref_entry(input logic [DW-1:0] n, input logic [DW-1:0] b,
                                              input int j);
    logic [DW+IW-1:0] p;
    p = (DW+IW)'(b) * (DW+IW)'(j);
    return DW'(p % (DW+IW)'(n));
  endfunction

  // B = 2^DW mod N
  function automatic logic [DW-1:0] pow2_mod(input logic [DW-1:0] n);
    logic [DW:0] p;
    p     = '0;
    p[DW] = 1'b1;
    return DW'(p % {1'b0, n});
  endfunction

  // Full run: mode 0 always ready, 1 toggling ready, 2 random ready.
  // A junk start pulse is injected at cycle inj_cyc (negative: none).
  task automatic run_table(input string name, input logic [DW-1:0] n, input logic [DW-1:0] b,
                           input int mode, input int inj_cyc, input bit chk_data);
    logic [DW-1:0] exp_t [DEPTH];
    logic [IW-1:0] h_addr;
    logic [DW-1:0] h_data;
    bit            held;
    int            k, stalls, done_cyc;
    for (int j = 0; j < DEPTH; j++) exp_t[j] = ref_entry(n, b, j);
    k = 0; stalls = 0; done_cyc = -1; held = 1'b0;
    h_addr = '0; h_data = '0;
    @(posedge clk); #1;
    start = 1'b1; modulus = n; base = b; wr_ready = 1'b1;
    for (int c = 1; c <= BUDGET; c++) begin
      @(posedge clk); #1;
      start = (c == inj_cyc);
      if (c == inj_cyc) begin
        modulus = n + DW'(2);
        base    = b >> 1;
      end
      case (mode)
        0:       wr_ready = 1'b1;
        1:       wr_ready = (c % 2 == 1);
        default: wr_ready = ($urandom_range(0, 2) != 0);
      endcase
      n_checks++;
      if (busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s busy c=%0d: got %b want 1", name, c, busy);
      end
      if (held) begin
        n_checks++;
        if (wr_valid !== 1'b1 || wr_addr !== h_addr || wr_data !== h_data) begin
          n_fail++;
          $display("FAIL %s stall_hold c=%0d: got v=%b a=%0d d=%h want v=1 a=%0d d=%h",
                   name, c, wr_valid, wr_addr, wr_data[63:0], h_addr, h_data[63:0]);
        end
      end
      held = 1'b0;
      if (wr_valid === 1'b1) begin
        if (wr_ready) begin
          n_checks++;
          if (k >= DEPTH || wr_addr !== IW'(k) || c != 1 + 3 * k + stalls ||
              (chk_data && wr_data !== exp_t[k % DEPTH])) begin
            n_fail++;
            $display("FAIL %s write k=%0d: got a=%0d d=%h cyc=%0d want a=%0d d=%h cyc=%0d",
                     name, k, wr_addr, wr_data[63:0], c, k, exp_t[k % DEPTH][63:0],
                     1 + 3 * k + stalls);
          end
          k++;
        end else begin
          stalls++;
          held   = 1'b1;
          h_addr = wr_addr;
          h_data = wr_data;
        end
      end
      if (done === 1'b1) begin
        done_cyc = c;
        break;
      end
    end
    n_checks++;
    if (done_cyc != 3 * DEPTH - 1 + stalls || k != DEPTH || err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s completion: got done_cyc=%0d writes=%0d err=%b want %0d %0d 0",
               name, done_cyc, k, err, 3 * DEPTH - 1 + stalls, DEPTH);
    end
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || wr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after_done: got busy=%b done=%b v=%b want 0 0 0",
               name, busy, done, wr_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; wr_ready = 1'b1; modulus = '0; base = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || wr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got busy=%b done=%b err=%b v=%b want 0 0 0 0",
               busy, done, err, wr_valid);
    end
    n_checks++;
    if (wr_addr !== '0 || wr_data !== '0) begin
      n_fail++;
      $display("FAIL reset_port: got a=%0d d=%h want 0 0", wr_addr, wr_data[63:0]);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    run_table("basic_7_3", DW'(7), DW'(3), 0, -1, 1'b1);
    run_table("basic_13_5", DW'(13), DW'(5), 0, -1, 1'b1);
  endtask

  task automatic test_stall();
    run_table("stall_toggle", DW'(7), DW'(3), 1, -1, 1'b1);
  endtask

  task automatic test_random_wide();
    logic [DW-1:0] n;
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < DW / 32; i++) n[32*i +: 32] = $urandom();
      n[DW-1] = 1'b1;
      n[0]    = 1'b1;
      run_table("wide_rand", n, pow2_mod(n), (t == 0) ? 0 : 2, -1, 1'b1);
    end
  endtask

  task automatic test_range_check();
`ifdef XPB_GEN_RANGE_CHECK_EN
    @(posedge clk); #1;
    start = 1'b1; modulus = DW'(7); base = DW'(9);
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (done !== 1'b1 || err !== 1'b1 || wr_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL range_abort: got done=%b err=%b v=%b busy=%b want 1 1 0 1",
               done, err, wr_valid, busy);
    end
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || wr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL range_idle: got busy=%b done=%b v=%b want 0 0 0", busy, done, wr_valid);
    end
    // err must clear on the next good start
    run_table("range_recover", DW'(7), DW'(3), 0, -1, 1'b1);
`else
    run_table("range_unchecked", DW'(7), DW'(9), 0, -1, 1'b0);
`endif
  endtask

  task automatic test_start_ignored();
    run_table("start_midrun", DW'(11), DW'(4), 0, 5, 1'b1);
    run_table("start_at_done", DW'(11), DW'(4), 0, 3 * DEPTH - 1, 1'b1);
  endtask

  task automatic test_reset_mid();
    int k;
    bit seen_bad;
    k = 0;
    @(posedge clk); #1;
    start = 1'b1; modulus = DW'(7); base = DW'(3); wr_ready = 1'b1;
    for (int c = 1; c <= BUDGET && k < 4; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (wr_valid === 1'b1 && wr_ready) k++;
    end
    n_checks++;
    if (k != 4) begin
      n_fail++;
      $display("FAIL reset_mid_reach: got writes=%0d want 4", k);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_checks++;
    if (wr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got v=%b busy=%b done=%b want 0 0 0", wr_valid, busy, done);
    end
    seen_bad = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (wr_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) seen_bad = 1'b1;
    end
    n_checks++;
    if (seen_bad) begin
      n_fail++;
      $display("FAIL reset_mid_quiet: got activity after abort want none");
    end
    run_table("after_reset", DW'(7), DW'(3), 0, -1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_random_wide();
    test_range_check();
    test_start_ignored();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
